// File: rtl/abs_diff_err_monitor.sv
// rtl/abs_diff_err_monitor.sv - exhaustive sweep and error statistics for approximate abs_diff circuits
module abs_diff_err_monitor #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 2,
    localparam int OP_W  = IN_W / 2,
    localparam int ERR_W = (OP_W > OUT_W) ? OP_W : OUT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [IN_W-1:0]       pi_o,
    input  logic [OUT_W-1:0]      po_i,
    output logic                  busy,
    output logic                  done,
    output logic [IN_W:0]         err_count,
    output logic [ERR_W-1:0]      err_max,
    output logic [IN_W+ERR_W-1:0] err_sum,
    output logic [IN_W-1:0]       first_fail,
    output logic                  first_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IN_W-1:0] LAST_VEC = {IN_W{1'b1}};

    state_t           state;
    logic [OP_W-1:0]  op_a;
    logic [OP_W-1:0]  op_b;
    logic [OP_W-1:0]  exact;
    logic [ERR_W-1:0] exact_ext;
    logic [ERR_W-1:0] po_ext;
    logic [ERR_W-1:0] err;

    // The response path is purely combinational so vector v is scored in the cycle it is driven.
    always_comb begin
        op_a      = pi_o[OP_W-1:0];
        op_b      = pi_o[IN_W-1:OP_W];
        exact     = (op_a >= op_b) ? (op_a - op_b) : (op_b - op_a);
        exact_ext = ERR_W'(exact);
        po_ext    = ERR_W'(po_i);
        err       = (po_ext >= exact_ext) ? (po_ext - exact_ext) : (exact_ext - po_ext);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pi_o        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_count   <= '0;
            err_max     <= '0;
            err_sum     <= '0;
            first_fail  <= '0;
            first_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= RUN;
                        pi_o        <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        err_count   <= '0;
                        err_max     <= '0;
                        err_sum     <= '0;
                        first_fail  <= '0;
                        first_valid <= 1'b0;
                    end
                end
                RUN: begin
                    if (err != '0) begin
                        err_count <= err_count + (IN_W+1)'(1);
                    end
                    err_sum <= err_sum + (IN_W+ERR_W)'(err);
                    if (err > err_max) begin
                        err_max <= err;
                    end
                    if (err != '0 && !first_valid) begin
                        first_fail  <= pi_o;
                        first_valid <= 1'b1;
                    end
                    // The last vector stays on pi_o while DONE holds the results.
                    if (pi_o == LAST_VEC) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        pi_o <= pi_o + (IN_W)'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_abs_diff_err_monitor.sv
// tb/tb_abs_diff_err_monitor.sv - directed sweeps of abs_diff_err_monitor against modelled DUT outputs
module tb_abs_diff_err_monitor;

    localparam int IN_W  = 4;
    localparam int OUT_W = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   pi_o;
    logic [1:0]   po_i;
    logic         busy;
    logic         done;
    logic [4:0]   err_count;
    logic [1:0]   err_max;
    logic [5:0]   err_sum;
    logic [3:0]   first_fail;
    logic         first_valid;

    int tests = 0;
    int fails = 0;
    int mode  = 0;

    typedef struct {
        int cnt;
        int sum;
        int mx;
        int ff;
        int fv;
    } exp_t;

    exp_t sb[$];

    abs_diff_err_monitor #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pi_o        (pi_o),
        .po_i        (po_i),
        .busy        (busy),
        .done        (done),
        .err_count   (err_count),
        .err_max     (err_max),
        .err_sum     (err_sum),
        .first_fail  (first_fail),
        .first_valid (first_valid)
    );

    always #5 clk = ~clk;

    // mode 0: exact |a-b|, mode 1: stuck at zero, mode 2: stuck at three
    logic [1:0] m_a;
    logic [1:0] m_b;
    always_comb begin
        m_a  = pi_o[1:0];
        m_b  = pi_o[3:2];
        po_i = 2'd0;
        case (mode)
            0:       po_i = (m_a >= m_b) ? (m_a - m_b) : (m_b - m_a);
            1:       po_i = 2'd0;
            default: po_i = 2'd3;
        endcase
    end

    function automatic exp_t expect_for(input int m);
        exp_t e;
        case (m)
            0:       e = '{cnt: 0,  sum: 0,  mx: 0, ff: 0, fv: 0};
            1:       e = '{cnt: 12, sum: 20, mx: 3, ff: 1, fv: 1};
            default: e = '{cnt: 14, sum: 28, mx: 3, ff: 0, fv: 1};
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_pi_o"}, 32'(pi_o), 0);
        check({tag, "_count"}, 32'(err_count), 0);
        check({tag, "_max"}, 32'(err_max), 0);
        check({tag, "_sum"}, 32'(err_sum), 0);
        check({tag, "_ff"}, 32'(first_fail), 0);
        check({tag, "_fv"}, 32'(first_valid), 0);
    endtask

    // Called at the negedge of cycle 1; returns the cycle in which done was first seen.
    task automatic wait_done(input logic hold, input int p1, input int p2, output int n);
        n = 1;
        while (done !== 1'b1 && n < 100) begin
            start = hold || (n == p1) || (n == p2);
            if (n == 6) check("pi_o_run", 32'(pi_o), 5);
            @(negedge clk);
            n++;
        end
        if (!hold) start = 1'b0;
        check("done_cycle", n, 17);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        tests++;
        assert (sb.size() > 0) else begin
            fails++;
            $error("FAIL %s_sb: observed %0d expected %0d", tag, 0, 1);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_count"}, 32'(err_count), e.cnt);
            check({tag, "_sum"}, 32'(err_sum), e.sum);
            check({tag, "_max"}, 32'(err_max), e.mx);
            check({tag, "_ff"}, 32'(first_fail), e.ff);
            check({tag, "_fv"}, 32'(first_valid), e.fv);
            check({tag, "_busy"}, 32'(busy), 0);
            check({tag, "_pi_done"}, 32'(pi_o), 15);
        end
    endtask

    task automatic sweep(input string tag, input int m, input int p1, input int p2);
        int n;
        mode = m;
        sb.push_back(expect_for(m));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy1"}, 32'(busy), 1);
        check({tag, "_pi1"}, 32'(pi_o), 0);
        wait_done(1'b0, p1, p2, n);
        pop_check(tag);
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);

        sweep("exact", 0, 0, 0);
        sweep("zero", 1, 0, 0);
        sweep("three", 2, 0, 0);
        sweep("ignore_start", 1, 3, 9);

        // Abort mid-sweep, then a clean sweep afterwards.
        mode  = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (n < 8) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_cleared("abort");
        sweep("after_abort", 1, 0, 0);

        // Back-to-back with start held in DONE: po=3 then po=0.
        mode = 2;
        sb.push_back(expect_for(2));
        start = 1'b1;
        @(negedge clk);
        check("b2b1_busy1", 32'(busy), 1);
        wait_done(1'b1, 0, 0, n);
        pop_check("b2b1");
        mode = 1;
        sb.push_back(expect_for(1));
        @(negedge clk);
        start = 1'b0;
        check("b2b2_busy1", 32'(busy), 1);
        check("b2b2_done1", 32'(done), 0);
        check("b2b2_cleared", 32'(err_count), 0);
        wait_done(1'b0, 0, 0, n);
        pop_check("b2b2");

        check("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
